// File: rtl/phrase_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// tracker_pkg
//   Types and constants shared by the phrase store and the phrase sequencer:
//   the phrase word layout, the empty-word marker, the highest playable note,
//   the sequencer state encoding and a helper that classifies a channel word.
// -----------------------------------------------------------------------------
package tracker_pkg;

  localparam logic [15:0] PHRASE_EMPTY = 16'hFFFF;
  localparam logic [7:0]  NOTE_MAX     = 8'd107;
  localparam int          PHRASE_ROWS  = 16;
  localparam int          NUM_CH       = 4;

  typedef struct packed {
    logic [7:0] note;
    logic [5:0] vol;
    logic [1:0] inst;
  } phrase_entry_t;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT, S_WAIT} seq_state_t;

  // What a channel word does to its channel when the row is emitted.
  typedef enum logic [1:0] {
    W_HOLD,  // empty or unplayable note: leave every field alone
    W_MUTE,  // latch fields, silence the channel
    W_PLAY   // latch fields, open the gate and fire a trigger
  } word_action_t;

  function automatic word_action_t classify(input logic [15:0] word);
    phrase_entry_t entry;
    entry = phrase_entry_t'(word);
    if (word == PHRASE_EMPTY || entry.note > NOTE_MAX) return W_HOLD;
    if (entry.vol == 6'd0)                             return W_MUTE;
    return W_PLAY;
  endfunction

endpackage

// File: rtl/phrase_sequencer_if.sv
// -----------------------------------------------------------------------------
// phrase_sequencer_if
//   Bundles the sequencer's control inputs, the four phrase-store words and the
//   decoded per-channel outputs.
//   master : transport control + phrase store side (drives play/tempo/words)
//   slave  : the sequencer (drives row index, channel registers and strobes)
// -----------------------------------------------------------------------------
interface phrase_sequencer_if;
  logic        play_pause;
  logic [7:0]  tempo_bpm;
  logic [15:0] channel_0;
  logic [15:0] channel_1;
  logic [15:0] channel_2;
  logic [15:0] channel_3;
  logic [3:0]  row;
  logic [31:0] ch_note;
  logic [23:0] ch_vol;
  logic [7:0]  ch_inst;
  logic [3:0]  ch_gate;
  logic [3:0]  ch_trig;
  logic        row_strobe;
  logic        phrase_wrap;

  modport master (
    output play_pause, tempo_bpm, channel_0, channel_1, channel_2, channel_3,
    input  row, ch_note, ch_vol, ch_inst, ch_gate, ch_trig, row_strobe, phrase_wrap
  );

  modport slave (
    input  play_pause, tempo_bpm, channel_0, channel_1, channel_2, channel_3,
    output row, ch_note, ch_vol, ch_inst, ch_gate, ch_trig, row_strobe, phrase_wrap
  );
endinterface

// File: rtl/phrase_sequencer_tempo_tick_gen.sv
// -----------------------------------------------------------------------------
// tempo_tick_gen
//   Phase accumulator that converts a BPM value into row ticks. Every cycle it
//   adds tempo_bpm*ROWS_PER_BEAT; when the sum reaches CLK_HZ*60 it subtracts
//   the threshold (keeping the remainder) and raises tick for that cycle.
//   Ports:
//     clk, rst_active_high : clock, asynchronous active-high reset
//     clr                  : synchronous clear of the accumulator
//     tempo_bpm            : BPM increment source; 0 holds the accumulator
//     tick                 : combinational, high when this cycle's sum crosses
// -----------------------------------------------------------------------------
module tempo_tick_gen #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int ROWS_PER_BEAT = 4,
  parameter int ACC_W         = 34
) (
  input  logic       clk,
  input  logic       rst_active_high,
  input  logic       clr,
  input  logic [7:0] tempo_bpm,
  output logic       tick
);

  localparam logic [ACC_W-1:0] THRESH = ACC_W'(64'(CLK_HZ) * 64'd60);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] sum;

  // The remainder after a subtract is always below the increment, so with a
  // zero increment the sum can never reach the threshold.
  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    inc   = ACC_W'(tempo_bpm) * ACC_W'(ROWS_PER_BEAT);
    sum   = acc_q + inc;
    tick  = 1'b0;
    acc_d = sum;
    if (clr) begin
      acc_d = '0;
    end else if (sum >= THRESH) begin
      tick  = 1'b1;
      acc_d = sum - THRESH;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) acc_q <= '0;
    else                 acc_q <= acc_d;
  end

endmodule

// File: rtl/phrase_sequencer.sv
// -----------------------------------------------------------------------------
// phrase_sequencer
//   Steps a 16-row phrase at the tempo rate, presents the row index to the
//   phrase store, and decodes the four returned words into per-channel
//   note/volume/instrument/gate registers with one-cycle trigger pulses.
//   Ports:
//     clk, rst_active_high : clock, asynchronous active-high reset
//     bus (slave)          : play_pause, tempo_bpm, channel_0..3 in;
//                            row, ch_note, ch_vol, ch_inst, ch_gate, ch_trig,
//                            row_strobe, phrase_wrap out (all registered)
// -----------------------------------------------------------------------------
module phrase_sequencer
  import tracker_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int ROWS_PER_BEAT = 4,
  parameter int ACC_W         = 34
) (
  input logic               clk,
  input logic               rst_active_high,
  phrase_sequencer_if.slave bus
);

  seq_state_t                   state_q, state_d;
  logic [3:0]                   row_q, row_d;
  logic [NUM_CH-1:0][7:0]       note_q, note_d;
  logic [NUM_CH-1:0][5:0]       vol_q, vol_d;
  logic [NUM_CH-1:0][1:0]       inst_q, inst_d;
  logic [NUM_CH-1:0]            gate_q, gate_d;
  logic [NUM_CH-1:0]            trig_q, trig_d;
  logic                         strobe_q, strobe_d;
  logic                         wrap_q, wrap_d;

  logic [15:0]                  words [NUM_CH];
  logic                         acc_clr;
  logic                         tick;
  logic [7:0]                   tempo_gated;
  phrase_entry_t                entry;

  assign words[0] = bus.channel_0;
  assign words[1] = bus.channel_1;
  assign words[2] = bus.channel_2;
  assign words[3] = bus.channel_3;

  // Only S_WAIT advances the phase; FETCH/EMIT cycles do not count toward a row.
  assign tempo_gated = (state_q == S_WAIT) ? bus.tempo_bpm : 8'd0;

  tempo_tick_gen #(
    .CLK_HZ       (CLK_HZ),
    .ROWS_PER_BEAT(ROWS_PER_BEAT),
    .ACC_W        (ACC_W)
  ) u_tick (
    .clk            (clk),
    .rst_active_high(rst_active_high),
    .clr            (acc_clr),
    .tempo_bpm      (tempo_gated),
    .tick           (tick)
  );

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    note_d   = note_q;
    vol_d    = vol_q;
    inst_d   = inst_q;
    gate_d   = gate_q;
    trig_d   = '0;
    strobe_d = 1'b0;
    wrap_d   = 1'b0;
    acc_clr  = 1'b0;
    entry    = '0;

    // Pause has priority over any tick or emit happening in the same cycle.
    if (!bus.play_pause) begin
      state_d = S_IDLE;
      gate_d  = '0;
      acc_clr = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          row_d   = '0;
          acc_clr = 1'b1;
          state_d = S_FETCH;
        end
        S_FETCH: state_d = S_EMIT;
        S_EMIT: begin
          for (int ch = 0; ch < NUM_CH; ch++) begin
            entry = phrase_entry_t'(words[ch]);
            if (classify(words[ch]) != W_HOLD) begin
              note_d[ch] = entry.note;
              vol_d[ch]  = entry.vol;
              inst_d[ch] = entry.inst;
              gate_d[ch] = (classify(words[ch]) == W_PLAY);
              trig_d[ch] = (classify(words[ch]) == W_PLAY);
            end
          end
          strobe_d = 1'b1;
          wrap_d   = (row_q == 4'(PHRASE_ROWS - 1));
          state_d  = S_WAIT;
        end
        S_WAIT: begin
          if (tick) begin
            row_d   = row_q + 4'd1;  // modulo-16 by width
            state_d = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: the channel field arrays are ordinary flops rather than a RAM, so
  // they take the asynchronous reset along with the rest of the state.
  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      note_q   <= '0;
      vol_q    <= '0;
      inst_q   <= '0;
      gate_q   <= '0;
      trig_q   <= '0;
      strobe_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      note_q   <= note_d;
      vol_q    <= vol_d;
      inst_q   <= inst_d;
      gate_q   <= gate_d;
      trig_q   <= trig_d;
      strobe_q <= strobe_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bus.row         = row_q;
  assign bus.ch_note     = note_q;
  assign bus.ch_vol      = vol_q;
  assign bus.ch_inst     = inst_q;
  assign bus.ch_gate     = gate_q;
  assign bus.ch_trig     = trig_q;
  assign bus.row_strobe  = strobe_q;
  assign bus.phrase_wrap = wrap_q;

endmodule

// File: tb/tb_phrase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phrase_sequencer
//   Directed scenarios followed by a randomized phrase/tempo/transport run,
//   compared every cycle against a countdown-based reference model of the
//   playback rules.
// -----------------------------------------------------------------------------
module tb_phrase_sequencer;
  import tracker_pkg::*;

  localparam int CLK_HZ = 1000;
  localparam int THRESH = CLK_HZ * 60;

  logic clk = 1'b0;
  logic rst_active_high = 1'b1;
  always #5 clk = ~clk;

  phrase_sequencer_if bus ();

  logic [15:0] phrase [16][4];
  assign bus.channel_0 = phrase[bus.row][0];
  assign bus.channel_1 = phrase[bus.row][1];
  assign bus.channel_2 = phrase[bus.row][2];
  assign bus.channel_3 = phrase[bus.row][3];

  phrase_sequencer #(
    .CLK_HZ       (CLK_HZ),
    .ROWS_PER_BEAT(4),
    .ACC_W        (34)
  ) dut (
    .clk            (clk),
    .rst_active_high(rst_active_high),
    .bus            (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Playback is a sequence of "emit" events; m_pending counts the edges until
  // the next emit, m_accum says the tempo phase is running between emits.
  int          m_acc;
  int          m_row;
  int          m_pending;
  bit          m_running;
  bit          m_accum;
  logic [7:0]  m_note [4];
  logic [5:0]  m_vol  [4];
  logic [1:0]  m_inst [4];
  logic [3:0]  m_gate;
  logic [3:0]  m_trig;
  logic        m_strobe;
  logic        m_wrap;

  task automatic model_reset();
    m_acc = 0; m_row = 0; m_pending = -1; m_running = 0; m_accum = 0;
    for (int c = 0; c < 4; c++) begin
      m_note[c] = '0; m_vol[c] = '0; m_inst[c] = '0;
    end
    m_gate = '0; m_trig = '0; m_strobe = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_emit();
    logic [15:0] w;
    for (int c = 0; c < 4; c++) begin
      w = phrase[m_row][c];
      if (w != 16'hFFFF && w[15:8] <= 8'd107) begin
        m_note[c] = w[15:8];
        m_vol[c]  = w[7:2];
        m_inst[c] = w[1:0];
        m_gate[c] = (w[7:2] != 6'd0);
        m_trig[c] = (w[7:2] != 6'd0);
      end
    end
    m_strobe = 1'b1;
    m_wrap   = (m_row == 15);
  endtask

  task automatic model_edge();
    m_trig = '0; m_strobe = 1'b0; m_wrap = 1'b0;
    if (!bus.play_pause) begin
      m_running = 0; m_accum = 0; m_pending = -1; m_acc = 0; m_gate = '0;
      return;
    end
    if (!m_running) begin
      m_running = 1; m_row = 0; m_acc = 0; m_pending = 2;
      return;
    end
    if (m_pending > 0) begin
      m_pending--;
      if (m_pending == 0) begin
        model_emit();
        m_accum = 1; m_pending = -1;
      end
      return;
    end
    if (m_accum) begin
      m_acc += int'(bus.tempo_bpm) * 4;
      if (m_acc >= THRESH) begin
        m_acc -= THRESH;
        m_row = (m_row + 1) % 16;
        m_accum = 0; m_pending = 2;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] en;
    logic [23:0] ev;
    logic [7:0]  ei;
    for (int c = 0; c < 4; c++) begin
      en[8*c +: 8] = m_note[c];
      ev[6*c +: 6] = m_vol[c];
      ei[2*c +: 2] = m_inst[c];
    end
    check("row",    32'(bus.row),         32'(m_row));
    check("note",   bus.ch_note,          en);
    check("vol",    32'(bus.ch_vol),      32'(ev));
    check("inst",   32'(bus.ch_inst),     32'(ei));
    check("gate",   32'(bus.ch_gate),     32'(m_gate));
    check("trig",   32'(bus.ch_trig),     32'(m_trig));
    check("strobe", 32'(bus.row_strobe),  32'(m_strobe));
    check("wrap",   32'(bus.phrase_wrap), 32'(m_wrap));
  endtask

  // One clock: model advances on the same edge the DUT samples, outputs are
  // compared 1 ns later. Inputs are only changed by the caller afterwards.
  task automatic cycle();
    @(posedge clk);
    if (rst_active_high) model_reset();
    else                 model_edge();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_strobe(input int max_cycles, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!bus.row_strobe && n < max_cycles);
    check("strobe_seen", 32'(bus.row_strobe), 32'd1);
  endtask

  int n;
  int r;

  initial begin
    model_reset();
    for (int rr = 0; rr < 16; rr++)
      for (int c = 0; c < 4; c++) phrase[rr][c] = 16'hFFFF;
    phrase[0][0] = 16'h3CC8;  // note 0x3C, vol 50, inst 0
    phrase[0][1] = 16'h2D05;  // note 0x2D, vol 1, inst 1
    phrase[0][2] = 16'h6B7F;  // note 107 (highest playable), vol 31, inst 3
    phrase[0][3] = 16'h6CFF;  // note 108: treated as empty
    bus.play_pause = 1'b1;
    bus.tempo_bpm  = 8'd150;

    // 1: reset held with play asserted -> everything zero
    run(3);
    check("rst_row",  32'(bus.row),        32'd0);
    check("rst_note", bus.ch_note,         32'd0);
    check("rst_gate", 32'(bus.ch_gate),    32'd0);
    check("rst_strb", 32'(bus.row_strobe), 32'd0);
    rst_active_high = 1'b0;
    wait_strobe(10, n);
    check("play_latency", 32'(n), 32'd3);

    // 2: row 0 decode
    check("r0_row",    32'(bus.row),          32'd0);
    check("r0_note0",  32'(bus.ch_note[7:0]), 32'h3C);
    check("r0_vol0",   32'(bus.ch_vol[5:0]),  32'd50);
    check("r0_inst0",  32'(bus.ch_inst[1:0]), 32'd0);
    check("r0_gate0",  32'(bus.ch_gate[0]),   32'd1);
    check("r0_trig0",  32'(bus.ch_trig[0]),   32'd1);
    check("r0_note2",  32'(bus.ch_note[23:16]), 32'h6B);
    check("r0_trig2",  32'(bus.ch_trig[2]),   32'd1);
    check("r0_note3",  32'(bus.ch_note[31:24]), 32'd0);
    check("r0_gate3",  32'(bus.ch_gate[3]),   32'd0);
    cycle();
    check("trig_pulse_1cyc", 32'(bus.ch_trig), 32'd0);
    wait_strobe(200, n);
    check("row_period_first", 32'(n + 1), 32'd102);
    check("row1", 32'(bus.row), 32'd1);

    // 3: empty rows hold gates, wrap at 15
    for (int k = 2; k < 16; k++) begin
      wait_strobe(200, n);
      check("row_period", 32'(n), 32'd102);
      check("empty_no_trig", 32'(bus.ch_trig), 32'd0);
      check("empty_gate_held", 32'(bus.ch_gate), 32'b0111);
    end
    check("wrap_at_15", 32'(bus.phrase_wrap), 32'd1);
    check("row_15", 32'(bus.row), 32'd15);
    phrase[1][0] = 16'h3C00;  // vol 0
    phrase[1][1] = 16'h70F9;  // note 0x70 > 107: held
    wait_strobe(200, n);
    check("wrapped_row0", 32'(bus.row), 32'd0);
    check("no_wrap_row0", 32'(bus.phrase_wrap), 32'd0);

    // 4: vol 0 drops the gate, note > 107 holds everything
    wait_strobe(200, n);
    check("r1_gate0_off",  32'(bus.ch_gate[0]),     32'd0);
    check("r1_trig0",      32'(bus.ch_trig[0]),     32'd0);
    check("r1_note0",      32'(bus.ch_note[7:0]),   32'h3C);
    check("r1_note1_held", 32'(bus.ch_note[15:8]),  32'h2D);
    check("r1_vol1_held",  32'(bus.ch_vol[11:6]),   32'd1);
    check("r1_gate1_held", 32'(bus.ch_gate[1]),     32'd1);
    check("r1_trig1",      32'(bus.ch_trig[1]),     32'd0);

    // 5: pause in the same cycle as a tick
    n = 0;
    while (!(m_accum && m_acc + int'(bus.tempo_bpm) * 4 >= THRESH) && n < 200) begin
      cycle();
      n++;
    end
    check("tick_reached", 32'(n < 200), 32'd1);
    bus.play_pause = 1'b0;
    cycle();
    check("pause_gate",   32'(bus.ch_gate),    32'd0);
    check("pause_strobe", 32'(bus.row_strobe), 32'd0);
    check("pause_row",    32'(bus.row),        32'd1);
    run(5);
    check("pause_note_held", 32'(bus.ch_note[7:0]), 32'h3C);
    bus.play_pause = 1'b1;
    wait_strobe(10, n);
    check("replay_latency", 32'(n), 32'd3);
    check("replay_row0",    32'(bus.row), 32'd0);

    // 6: tempo 0 freezes the row, resume keeps the accumulated phase
    run(30);
    bus.tempo_bpm = 8'd0;
    run(10000);
    check("frozen_row", 32'(bus.row), 32'd0);
    bus.tempo_bpm = 8'd150;
    wait_strobe(200, n);
    check("resume_latency", 32'(n), 32'd72);
    check("resume_row1",    32'(bus.row), 32'd1);

    // Randomized phrase, tempo changes and transport toggles
    for (int rr = 0; rr < 16; rr++)
      for (int c = 0; c < 4; c++) begin
        case ($urandom_range(0, 3))
          0: phrase[rr][c] = 16'hFFFF;
          1: phrase[rr][c] = {8'($urandom_range(108, 255)), 8'($urandom_range(0, 255))};
          2: phrase[rr][c] = {8'($urandom_range(0, 107)), 6'd0, 2'($urandom_range(0, 3))};
          default: phrase[rr][c] = {8'($urandom_range(0, 107)), 6'($urandom_range(1, 63)),
                                    2'($urandom_range(0, 3))};
        endcase
      end
    bus.tempo_bpm = 8'd255;
    for (int i = 0; i < 4000; i++) begin
      cycle();
      r = int'($urandom_range(0, 999));
      if (r < 3) bus.play_pause = ~bus.play_pause;
      else if (r < 8) bus.tempo_bpm = 8'($urandom_range(0, 255));
      else if (!bus.play_pause && r < 60) bus.play_pause = 1'b1;
    end

    // Asynchronous reset mid-operation
    bus.play_pause = 1'b1;
    bus.tempo_bpm  = 8'd200;
    run(150);
    rst_active_high = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("async_rst_gate", 32'(bus.ch_gate), 32'd0);
    check("async_rst_row",  32'(bus.row),     32'd0);
    run(2);
    rst_active_high = 1'b0;
    wait_strobe(10, n);
    check("post_rst_latency", 32'(n), 32'd3);
    run(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
